// File: rtl/reg2519_ctl.sv
// reg2519_ctl: command sequencer for a bank of 25LS2519-style quad registers.
// Turns a single-cycle REQ/ACK command into ordered data-setup, clock-enable,
// output-enable and clear strobes. Every output is a flop.
// Optional build macro: REG2519_CTL_VERIFY_EN adds a read-back verify after
// every write and drives ERR; without it ERR stays 0.
module reg2519_ctl #(
    parameter int NREG       = 4,
    parameter int AW         = 2,
    parameter int CLR_CYCLES = 2
) (
    input  logic            CLK,
    input  logic            ASYN_CLR_N,
    input  logic            REQ,
    input  logic            WE,
    input  logic            CLR,
    input  logic [AW-1:0]   ADDR,
    input  logic [3:0]      DATA_IN,
    input  logic            INV_IN,
    input  logic [3:0]      RD_BUS,
    output logic [3:0]      I,
    output logic            INV,
    output logic [NREG-1:0] CLK_ENB_N,
    output logic [NREG-1:0] O_ENB_N,
    output logic            CLR_N,
    output logic [3:0]      DATA_OUT,
    output logic            ACK,
    output logic            BUSY,
    output logic            ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_SETUP,
        S_W_STROBE,
        S_W_HOLD,
        S_R_DRIVE,
        S_R_SAMPLE,
        S_CLEAR,
        S_C_RECOVER
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(CLR_CYCLES - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [3:0]      data_q, data_d;
    logic            inv_q, inv_d;
`ifdef REG2519_CTL_VERIFY_EN
    logic            wr_q, wr_d;
`endif
    logic [3:0]      clr_cnt_q, clr_cnt_d;

    logic            accept;
    logic            addr_valid;
    logic            addr_valid_d;
    logic [NREG-1:0] sel_d;
    logic            drive_d;
    logic            ack_d;
    logic [3:0]      rd_val;

    // A new command is taken in IDLE or in the ACK cycle of the previous one,
    // so REQ held high runs commands back to back without a dead cycle.
    assign accept       = REQ && ((state_q == S_IDLE) || ACK);
    assign addr_valid   = 32'(addr_q) < NREG;
    assign addr_valid_d = 32'(addr_d) < NREG;
    assign sel_d        = addr_valid_d ? (NREG'(1) << addr_d) : '0;
    // An out-of-range address enables nothing, so the bus reads as zero.
    assign rd_val       = addr_valid ? RD_BUS : 4'h0;

    // Next-state, command latch and output decode for the cycle after this edge.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        inv_d     = inv_q;
`ifdef REG2519_CTL_VERIFY_EN
        wr_d      = wr_q;
`endif
        clr_cnt_d = clr_cnt_q;

        if (accept) begin
            addr_d    = ADDR;
            data_d    = DATA_IN;
            inv_d     = INV_IN;
`ifdef REG2519_CTL_VERIFY_EN
            wr_d      = WE && !CLR;
`endif
            clr_cnt_d = '0;
            if (CLR)     state_d = S_CLEAR;
            else if (WE) state_d = S_W_SETUP;
            else         state_d = S_R_DRIVE;
        end else begin
            case (state_q)
                S_IDLE:      state_d = S_IDLE;
                S_W_SETUP:   state_d = S_W_STROBE;
                S_W_STROBE:  state_d = S_W_HOLD;
`ifdef REG2519_CTL_VERIFY_EN
                S_W_HOLD:    state_d = S_R_DRIVE;
`else
                S_W_HOLD:    state_d = S_IDLE;
`endif
                S_R_DRIVE:   state_d = S_R_SAMPLE;
                S_R_SAMPLE:  state_d = S_IDLE;
                S_CLEAR: begin
                    if (clr_cnt_q == CNT_LAST) begin
                        state_d = S_C_RECOVER;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 4'd1;
                    end
                end
                S_C_RECOVER: state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end

        drive_d = (state_d == S_W_SETUP) || (state_d == S_W_STROBE) ||
                  (state_d == S_W_HOLD);
`ifdef REG2519_CTL_VERIFY_EN
        ack_d   = (state_d == S_R_SAMPLE) || (state_d == S_C_RECOVER);
`else
        ack_d   = (state_d == S_W_HOLD) || (state_d == S_R_SAMPLE) ||
                  (state_d == S_C_RECOVER);
`endif
    end

    // State, command registers and registered strobes; reset forces the bank idle.
    always_ff @(posedge CLK or negedge ASYN_CLR_N) begin
        if (!ASYN_CLR_N) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            inv_q     <= 1'b0;
`ifdef REG2519_CTL_VERIFY_EN
            wr_q      <= 1'b0;
`endif
            clr_cnt_q <= '0;
            I         <= '0;
            INV       <= 1'b0;
            CLK_ENB_N <= '1;
            O_ENB_N   <= '1;
            CLR_N     <= 1'b1;
            DATA_OUT  <= '0;
            ACK       <= 1'b0;
            BUSY      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            inv_q     <= inv_d;
`ifdef REG2519_CTL_VERIFY_EN
            wr_q      <= wr_d;
`endif
            clr_cnt_q <= clr_cnt_d;
            I         <= drive_d ? data_d : 4'h0;
            INV       <= drive_d && inv_d;
            CLK_ENB_N <= (state_d == S_W_STROBE) ? ~sel_d : '1;
            O_ENB_N   <= ((state_d == S_R_DRIVE) || (state_d == S_R_SAMPLE)) ? ~sel_d : '1;
            CLR_N     <= (state_d != S_CLEAR);
            ACK       <= ack_d;
            BUSY      <= (state_d != S_IDLE);
            if (state_q == S_R_SAMPLE) begin
                DATA_OUT <= rd_val;
            end
`ifdef REG2519_CTL_VERIFY_EN
            // Compare at the end of R_DRIVE so ERR is already valid alongside ACK.
            if ((state_q == S_R_DRIVE) && wr_q) begin
                ERR <= (rd_val != (inv_q ? ~data_q : data_q));
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg2519_ctl.sv
// tb_reg2519_ctl: directed bench for reg2519_ctl with a behavioural register
// bank. Stimulus pushes expected strobe samples and ACK responses into queues;
// a monitor on the falling edge pops and compares them.
module tb_reg2519_ctl;

    localparam int NREG       = 4;
    localparam int AW         = 3;
    localparam int CLR_CYCLES = 2;
    localparam int IW         = $clog2(NREG);
`ifdef REG2519_CTL_VERIFY_EN
    localparam int WR_ACK     = 5;
    localparam bit ERR_ZERO   = 1'b0;
`else
    localparam int WR_ACK     = 3;
    localparam bit ERR_ZERO   = 1'b1;
`endif

    logic            CLK;
    logic            ASYN_CLR_N;
    logic            REQ;
    logic            WE;
    logic            CLR;
    logic [AW-1:0]   ADDR;
    logic [3:0]      DATA_IN;
    logic            INV_IN;
    logic [3:0]      RD_BUS;
    logic [3:0]      I;
    logic            INV;
    logic [NREG-1:0] CLK_ENB_N;
    logic [NREG-1:0] O_ENB_N;
    logic            CLR_N;
    logic [3:0]      DATA_OUT;
    logic            ACK;
    logic            BUSY;
    logic            ERR;

    reg2519_ctl #(.NREG(NREG), .AW(AW), .CLR_CYCLES(CLR_CYCLES)) dut (
        .CLK(CLK), .ASYN_CLR_N(ASYN_CLR_N), .REQ(REQ), .WE(WE), .CLR(CLR),
        .ADDR(ADDR), .DATA_IN(DATA_IN), .INV_IN(INV_IN), .RD_BUS(RD_BUS),
        .I(I), .INV(INV), .CLK_ENB_N(CLK_ENB_N), .O_ENB_N(O_ENB_N),
        .CLR_N(CLR_N), .DATA_OUT(DATA_OUT), .ACK(ACK), .BUSY(BUSY), .ERR(ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural register bank: stores on clock when enabled, drives A bus.
    logic [3:0] bank [NREG];
    logic       rd_force;

    always @(posedge CLK) begin
        for (int k = 0; k < NREG; k++) begin
            if (!CLR_N)                      bank[k[IW-1:0]] <= 4'h0;
            else if (!CLK_ENB_N[k[IW-1:0]])  bank[k[IW-1:0]] <= INV ? ~I : I;
        end
    end

    always_comb begin
        RD_BUS = 4'h0;
        if (!rd_force) begin
            for (int k = 0; k < NREG; k++) begin
                if (!O_ENB_N[k[IW-1:0]]) RD_BUS = bank[k[IW-1:0]];
            end
        end
    end

    typedef struct {
        int              cyc;
        logic [NREG-1:0] ce_n;
        logic [NREG-1:0] oe_n;
        logic            clr_n;
        logic [3:0]      i;
        logic            inv;
    } samp_t;

    typedef struct {
        int         cyc;
        bit         has_dout;
        logic [3:0] dout;
        bit         chk_err;
        logic       err;
    } resp_t;

    samp_t samp_q[$];
    resp_t resp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NREG-1:0] sel_n(input int a);
        logic [NREG-1:0] one;
        one = NREG'(1);
        if (a < NREG) return ~(one << a);
        return '1;
    endfunction

    task automatic push_samp(input int c, input logic [NREG-1:0] ce, input logic [NREG-1:0] oe,
                             input logic cn, input logic [3:0] iv, input logic inv);
        samp_t s;
        s.cyc = c; s.ce_n = ce; s.oe_n = oe; s.clr_n = cn; s.i = iv; s.inv = inv;
        samp_q.push_back(s);
    endtask

    task automatic push_wr(input int t0, input int a, input logic [3:0] d, input logic inv);
        resp_t      r;
        logic [3:0] stored;
        stored = inv ? ~d : d;
        for (int c = 1; c <= 3; c++) begin
            push_samp(t0 + c, (c == 2) ? sel_n(a) : '1, '1, 1'b1, d, inv);
        end
        r.cyc = t0 + WR_ACK;
`ifdef REG2519_CTL_VERIFY_EN
        r.has_dout = 1'b1;
        r.dout     = (a < NREG && !rd_force) ? stored : 4'h0;
        r.chk_err  = 1'b1;
        r.err      = (r.dout != stored);
`else
        r.has_dout = 1'b0;
        r.dout     = stored;
        r.chk_err  = 1'b1;
        r.err      = 1'b0;
`endif
        resp_q.push_back(r);
    endtask

    task automatic push_rd(input int t0, input int a, input logic [3:0] exp);
        resp_t r;
        for (int c = 1; c <= 2; c++) push_samp(t0 + c, '1, sel_n(a), 1'b1, 4'h0, 1'b0);
        r.cyc = t0 + 2; r.has_dout = 1'b1; r.dout = exp;
        r.chk_err = ERR_ZERO; r.err = 1'b0;
        resp_q.push_back(r);
    endtask

    task automatic push_clr(input int t0);
        resp_t r;
        for (int c = 1; c <= CLR_CYCLES + 1; c++) begin
            push_samp(t0 + c, '1, '1, (c == CLR_CYCLES + 1), 4'h0, 1'b0);
        end
        r.cyc = t0 + CLR_CYCLES + 1; r.has_dout = 1'b0; r.dout = 4'h0;
        r.chk_err = ERR_ZERO; r.err = 1'b0;
        resp_q.push_back(r);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Garbage on the command inputs once REQ drops must have no effect.
    task automatic scramble();
        REQ = 1'b0; WE = 1'b0; CLR = 1'b1; ADDR = ~ADDR; DATA_IN = ~DATA_IN; INV_IN = ~INV_IN;
    endtask

    task automatic do_wr(input int a, input logic [3:0] d, input logic inv);
        REQ = 1'b1; WE = 1'b1; CLR = 1'b0; ADDR = AW'(a); DATA_IN = d; INV_IN = inv;
        push_wr(cyc, a, d, inv);
        tick();
        scramble();
        repeat (WR_ACK) tick();
    endtask

    task automatic do_rd(input int a, input logic [3:0] exp);
        REQ = 1'b1; WE = 1'b0; CLR = 1'b0; ADDR = AW'(a); DATA_IN = 4'h0; INV_IN = 1'b0;
        push_rd(cyc, a, exp);
        tick();
        scramble();
        repeat (2) tick();
    endtask

    task automatic do_clr(input logic we);
        REQ = 1'b1; WE = we; CLR = 1'b1; ADDR = 3'd2; DATA_IN = 4'hF; INV_IN = 1'b0;
        push_clr(cyc);
        tick();
        scramble();
        repeat (CLR_CYCLES + 1) tick();
    endtask

    // Monitor: invariants every cycle, queued strobe samples, ACK responses.
    initial begin
        samp_t      s;
        resp_t      r;
        bit         pend = 1'b0;
        logic [3:0] pend_dout = 4'h0;
        forever begin
            @(negedge CLK);
            check("one_enable_max", 32'($countones(~{CLK_ENB_N, O_ENB_N}) <= 1), 32'd1);
            check("clr_with_enable", 32'(!CLR_N && ({CLK_ENB_N, O_ENB_N} != '1)), 32'd0);
            if (pend) begin
                check("data_out", 32'(DATA_OUT), 32'(pend_dout));
                pend = 1'b0;
            end
            if (samp_q.size() > 0 && samp_q[0].cyc == cyc) begin
                s = samp_q.pop_front();
                check("clk_enb_n", 32'(CLK_ENB_N), 32'(s.ce_n));
                check("o_enb_n", 32'(O_ENB_N), 32'(s.oe_n));
                check("clr_n", 32'(CLR_N), 32'(s.clr_n));
                check("i_data", 32'(I), 32'(s.i));
                check("inv", 32'(INV), 32'(s.inv));
                check("busy", 32'(BUSY), 32'd1);
            end
            if (ACK) begin
                if (resp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_ack: ACK high with nothing pending (cycle %0d)", cyc);
                end else begin
                    r = resp_q.pop_front();
                    check("ack_cycle", 32'(cyc), 32'(r.cyc));
                    check("busy_at_ack", 32'(BUSY), 32'd1);
                    if (r.chk_err) check("err_at_ack", 32'(ERR), 32'(r.err));
                    if (r.has_dout) begin
                        pend      = 1'b1;
                        pend_dout = r.dout;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    int         b2b_addr [3] = '{0, 1, 3};
    logic [3:0] b2b_data [3] = '{4'h1, 4'h2, 4'h3};
    logic       b2b_inv  [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        int t0;
        int k;
        ASYN_CLR_N = 1'b0; REQ = 1'b0; WE = 1'b0; CLR = 1'b0;
        ADDR = '0; DATA_IN = 4'h0; INV_IN = 1'b0; rd_force = 1'b0;
        repeat (3) tick();
        check("rst_i", 32'(I), 32'd0);
        check("rst_inv", 32'(INV), 32'd0);
        check("rst_clk_enb_n", 32'(CLK_ENB_N), 32'hF);
        check("rst_o_enb_n", 32'(O_ENB_N), 32'hF);
        check("rst_clr_n", 32'(CLR_N), 32'd1);
        check("rst_data_out", 32'(DATA_OUT), 32'd0);
        check("rst_ack", 32'(ACK), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        ASYN_CLR_N = 1'b1;
        tick();

        // Single writes and reads, including inverted storage.
        do_wr(2, 4'hA, 1'b0);
        do_wr(1, 4'h5, 1'b0);
        do_rd(1, 4'h5);
        do_rd(2, 4'hA);
        do_wr(3, 4'h6, 1'b1);
        do_rd(3, 4'h9);

        // Out-of-range addresses: no enables, read returns 0.
        do_rd(5, 4'h0);
        do_wr(6, 4'h7, 1'b0);

        // CLR together with WE performs a clear only.
        do_clr(1'b1);
        do_rd(2, 4'h0);
        do_rd(3, 4'h0);

        // Three back-to-back writes with REQ held, plus a REQ pulse while busy.
        t0 = cyc;
        for (int c = 0; c <= 2 * WR_ACK; c++) begin
            if (c % WR_ACK == 0) begin
                k = c / WR_ACK;
                REQ = 1'b1; WE = 1'b1; CLR = 1'b0;
                ADDR = AW'(b2b_addr[k]); DATA_IN = b2b_data[k]; INV_IN = b2b_inv[k];
                push_wr(cyc, b2b_addr[k], b2b_data[k], b2b_inv[k]);
            end else begin
                REQ = (c != 1); WE = 1'b0; CLR = 1'b1; ADDR = 3'd3; DATA_IN = 4'hF;
            end
            tick();
        end
        scramble();
        repeat (WR_ACK) tick();
        check("b2b_span", 32'(cyc - t0), 32'(3 * WR_ACK + 1));
        do_rd(0, 4'h1);
        do_rd(1, 4'h2);
        do_rd(3, 4'hC);

        // Inverted write whose read-back matches, then one with the bus forced low.
        do_wr(1, 4'h3, 1'b1);
        rd_force = 1'b1;
        do_wr(1, 4'h3, 1'b1);
        rd_force = 1'b0;
        do_rd(1, 4'hC);

        // Reset during W_STROBE: outputs drop at once, no ACK follows.
        REQ = 1'b1; WE = 1'b1; CLR = 1'b0; ADDR = 3'd0; DATA_IN = 4'hF; INV_IN = 1'b0;
        tick();
        REQ = 1'b0;
        tick();
        check("midrst_strobe_on", 32'(CLK_ENB_N), 32'hE);
        #2 ASYN_CLR_N = 1'b0;
        #1;
        check("midrst_clk_enb_n", 32'(CLK_ENB_N), 32'hF);
        check("midrst_busy", 32'(BUSY), 32'd0);
        check("midrst_i", 32'(I), 32'd0);
        check("midrst_ack", 32'(ACK), 32'd0);
        check("midrst_data_out", 32'(DATA_OUT), 32'd0);
        repeat (2) tick();
        ASYN_CLR_N = 1'b1;
        repeat (4) tick();
        check("post_rst_busy", 32'(BUSY), 32'd0);
        check("post_rst_err", 32'(ERR), 32'd0);
        do_rd(1, 4'hC);

        repeat (4) tick();
        check("resp_drained", 32'(resp_q.size()), 32'd0);
        check("samp_drained", 32'(samp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
